multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multi-cycle control unit for the RISC-V core. It generalises the single-cycle opcode decoder into a state machine that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It adds I-type ALU and JAL support, a memory request/ready handshake with arbitrary wait states, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register and the multi-cycle datapath muxes and enables.

Parameters:
CNT_W, 32, width of retired-instruction counter
TRAP_ON_ILLEGAL, 1, 1 = illegal opcode enters sticky TRAP state; 0 = treated as NOP (return to FETCH, counted as retired)
ENABLE_JAL, 1, 0 = opcode 1101111 treated as illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
op_code  in  7  instr[6:0] from instruction register
zero  in  1  ALU zero flag (valid in BEQ state)
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory access request
PCWrite  out  1  PC load enable
AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register / OldPC load enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 data
ALUSrcB  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
ALUOp  out  2  00 add, 01 subtract/compare, 10 funct-decoded
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
RegWrite  out  1  register-file write enable
illegal  out  1  sticky illegal-opcode flag
retired  out  CNT_W  retired-instruction count
state_o  out  4  current state encoding, debug

Behaviour:
- One clock, clk; rst synchronous active-high. Reset: state=FETCH, illegal=0, retired=0. In any cycle with rst=1 all enables (mem_req, PCWrite, MemWrite, IRWrite, RegWrite) are forced 0; muxes 0.
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11. Unused codes -> FETCH.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; -> DECODE when 1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=10 (branch target precompute). Next: lw/sw -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL (if ENABLE_JAL); else illegal handling.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=00 for lw, 01 for sw. -> MEMREAD (lw) / MEMWRITE (sw).
- MEMREAD: mem_req=1, AdrSrc=1; wait for mem_ready -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=mem_ready; wait for mem_ready -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, ImmSrc=11 (PC<=target from DECODE; ALU yields OldPC+4) -> ALUWB.
- Illegal in DECODE: TRAP_ON_ILLEGAL=1 -> TRAP, illegal<=1; TRAP holds all enables 0 until rst. TRAP_ON_ILLEGAL=0 -> FETCH, illegal unchanged.
- retired increments by 1 on the transition into FETCH from MEMWB, MEMWRITE (on mem_ready), ALUWB, BEQ, or DECODE (NOP case); wraps modulo 2^CNT_W. Entering TRAP does not count.
- Latencies with zero wait states: R/I/sw 4 cycles, lw 5, beq 3, jal 4. Each mem wait cycle adds one.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored. rst mid-instruction aborts immediately to FETCH; no partial writes issued in the reset cycle.
- Unlisted outputs in each state are 0.

Decomposition:
- Shared package riscv_ctrl_pkg: opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL), state encodings, ImmSrc/ALUSrcA/ALUSrcB/ResultSrc/ALUOp encodings.
- Sub-module: instr_type_decode (combinational op_code -> one-hot class incl. illegal, honouring ENABLE_JAL), feeding the FSM's DECODE transition.

Test Plan:
- rst=1 for 2 cycles, mem_ready=1 -> state_o=0, retired=0, illegal=0, all enables 0 during reset.
- op_code=0110011, mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in ALUWB; retired 0->1 after 4 cycles.
- op_code=0000011, mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> IRWrite/PCWrite pulse exactly once; MEMWB reached after 10 cycles; ResultSrc=01 with RegWrite=1.
- op_code=1100011, zero=1 then zero=0 on next beq -> PCWrite=1 in first BEQ cycle, 0 in second; each 3 cycles; retired +2.
- op_code=1101111, ENABLE_JAL=1 -> 0,1,10,8,0 with PCWrite=1 in JAL, RegWrite=1 in ALUWB; ENABLE_JAL=0 -> TRAP, illegal=1, held 20 cycles until rst.
- op_code=1111111, TRAP_ON_ILLEGAL=0 -> FETCH after DECODE, illegal=0, retired +1; rst asserted in MEMWRITE with mem_ready=1 -> MemWrite=0 that cycle, state_o=0 next.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: opcodes, FSM states,
// datapath mux selects and the instruction-class bundle produced by the decoder.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Exactly one bit is set for any opcode.
    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic itype;
        logic branch;
        logic jal;
        logic illegal;
    } instr_class_t;

    localparam int INSTR_CLASS_W = $bits(instr_class_t);

endpackage

// File: rtl/instr_type_decode.sv
// Combinational opcode classifier; yields a one-hot instruction class, with JAL
// folded into the illegal class when JAL support is disabled.
module instr_type_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int ENABLE_JAL = 1
) (
    input  logic [6:0]               op_code_i,
    output logic [INSTR_CLASS_W-1:0] class_o
);

    instr_class_t cls;

    always_comb begin
        cls = '0;
        case (op_code_i)
            OP_LOAD:   cls.load   = 1'b1;
            OP_STORE:  cls.store  = 1'b1;
            OP_RTYPE:  cls.rtype  = 1'b1;
            OP_ITYPE:  cls.itype  = 1'b1;
            OP_BRANCH: cls.branch = 1'b1;
            OP_JAL: begin
                if (ENABLE_JAL != 0) cls.jal     = 1'b1;
                else                 cls.illegal = 1'b1;
            end
            default:   cls.illegal = 1'b1;
        endcase
    end

    assign class_o = cls;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared ALU and memory port, with wait-state handshake, illegal trap and retire count.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int ENABLE_JAL      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op_code,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    state_t                   state_q, state_d;
    logic                     illegal_q, illegal_d;
    logic [CNT_W-1:0]         retired_q, retired_d;
    logic                     retire;
    logic                     set_illegal;
    logic [INSTR_CLASS_W-1:0] class_w;
    instr_class_t             cls;

    instr_type_decode #(
        .ENABLE_JAL (ENABLE_JAL)
    ) u_decode (
        .op_code_i (op_code),
        .class_o   (class_w)
    );

    assign cls = instr_class_t'(class_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (cls.load || cls.store) state_d = S_MEMADR;
                else if (cls.rtype)        state_d = S_EXECUTER;
                else if (cls.itype)        state_d = S_EXECUTEI;
                else if (cls.branch)       state_d = S_BEQ;
                else if (cls.jal)          state_d = S_JAL;
                else if (cls.illegal) begin
                    if (TRAP_ON_ILLEGAL != 0) begin
                        state_d     = S_TRAP;
                        set_illegal = 1'b1;
                    end else begin
                        // Unknown opcode executes as a NOP and still retires.
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_MEMADR:   state_d = cls.store ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWRITE: begin
                state_d = mem_ready ? S_FETCH : S_MEMWRITE;
                retire  = mem_ready;
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BEQ: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    assign illegal_d = illegal_q | set_illegal;
    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    // Reset overrides every state so no enable can escape during the reset cycle.
    always_comb begin
        mem_req   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        ImmSrc    = IMM_I;
        RegWrite  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_B;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = cls.store ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = mem_ready;
                end
                S_EXECUTER: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_EXECUTEI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB:    RegWrite = 1'b1;
                S_BEQ: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_SUB;
                    PCWrite = zero;
                end
                S_JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    ImmSrc  = IMM_J;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: an instruction-level model expands each opcode into its expected
// per-cycle trace, which is compared cycle by cycle against three parameter variants.
module tb_multicycle_control_fsm;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXR = 4'd6, ST_EXI = 4'd7, ST_ALUWB = 4'd8;
    localparam logic [3:0] ST_BEQ = 4'd9, ST_JAL = 4'd10, ST_TRAP = 4'd11;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        mr;
        logic        z;
        logic [6:0]  op;
        logic        ill;
        logic [31:0] ret;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0]       op_code;
    logic             zero;
    logic             mem_ready;
    logic [2:0]       rst_v;
    logic [2:0][15:0] ctl_a;
    logic [2:0][3:0]  st_a;
    logic [2:0]       ill_a;
    logic [2:0][31:0] ret_a;

    // Variant 0: defaults; 1: JAL disabled (traps); 2: illegal opcodes run as NOP.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            logic       mreq, pcw, adr, mw, irw, rw;
            logic [1:0] rs, asa, asb, aop, imm;
            multicycle_control_fsm #(
                .CNT_W           (32),
                .TRAP_ON_ILLEGAL ((gi == 2) ? 0 : 1),
                .ENABLE_JAL      ((gi == 1) ? 0 : 1)
            ) u_dut (
                .clk       (clk),
                .rst       (rst_v[gi]),
                .op_code   (op_code),
                .zero      (zero),
                .mem_ready (mem_ready),
                .mem_req   (mreq),
                .PCWrite   (pcw),
                .AdrSrc    (adr),
                .MemWrite  (mw),
                .IRWrite   (irw),
                .ResultSrc (rs),
                .ALUSrcA   (asa),
                .ALUSrcB   (asb),
                .ALUOp     (aop),
                .ImmSrc    (imm),
                .RegWrite  (rw),
                .illegal   (ill_a[gi]),
                .retired   (ret_a[gi]),
                .state_o   (st_a[gi])
            );
            assign ctl_a[gi] = {mreq, pcw, adr, mw, irw, rs, asa, asb, aop, imm, rw};
        end
    endgenerate

    int          n_cmp = 0;
    int          n_bad = 0;
    int          k     = 0;
    int unsigned ret_m = 0;
    logic        ill_m = 1'b0;
    ent_t        q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at t=%0t", tag, k, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic mreq, pcw, adr, mw, irw,
                                       input logic [1:0] rs, asa, asb, aop, imm,
                                       input logic rw);
        return {mreq, pcw, adr, mw, irw, rs, asa, asb, aop, imm, rw};
    endfunction

    task automatic push(input logic [3:0] st, input logic [15:0] c, input logic mr,
                        input logic z, input logic [6:0] op);
        ent_t e;
        e.st = st; e.ctl = c; e.mr = mr; e.z = z; e.op = op;
        e.ill = ill_m; e.ret = ret_m;
        q.push_back(e);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its expected cycle trace from the per-state rules.
    task automatic gen_instr(input logic [6:0] op, input int wf, input int wm,
                             input logic z, input int trap_cycles);
        logic legal;
        legal = (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BR)
                || (op == JL && k != 1);
        for (int i = 0; i < wf; i++)
            push(ST_FETCH, mk(1, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 0), 1'b0, rb(), 7'($urandom));
        push(ST_FETCH, mk(1, 1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 0), 1'b1, rb(), 7'($urandom));
        push(ST_DECODE, mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 0), rb(), rb(), op);
        if (!legal) begin
            if (k != 2) begin
                ill_m = 1'b1;
                for (int i = 0; i < trap_cycles; i++)
                    push(ST_TRAP, 16'h0, rb(), rb(), op);
            end else begin
                ret_m++;
            end
            return;
        end
        case (op)
            LW: begin
                push(ST_MEMADR, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 0), rb(), rb(), op);
                for (int i = 0; i < wm; i++)
                    push(ST_MEMREAD, mk(1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0), 1'b0, rb(), op);
                push(ST_MEMREAD, mk(1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0), 1'b1, rb(), op);
                push(ST_MEMWB, mk(0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1), rb(), rb(), op);
            end
            SW: begin
                push(ST_MEMADR, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd1, 0), rb(), rb(), op);
                for (int i = 0; i < wm; i++)
                    push(ST_MEMWRITE, mk(1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0), 1'b0, rb(), op);
                push(ST_MEMWRITE, mk(1, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0), 1'b1, rb(), op);
            end
            RT: begin
                push(ST_EXR, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 0), rb(), rb(), op);
                push(ST_ALUWB, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1), rb(), rb(), op);
            end
            IT: begin
                push(ST_EXI, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 0), rb(), rb(), op);
                push(ST_ALUWB, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1), rb(), rb(), op);
            end
            BR: push(ST_BEQ, mk(0, z, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 0), rb(), z, op);
            default: begin
                push(ST_JAL, mk(0, 1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 0), rb(), rb(), op);
                push(ST_ALUWB, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1), rb(), rb(), op);
            end
        endcase
        ret_m++;
    endtask

    task automatic step(input ent_t e);
        @(negedge clk);
        rst_v[k]  = 1'b0;
        op_code   = e.op;
        mem_ready = e.mr;
        zero      = e.z;
        #1;
        check_eq("state", 32'(st_a[k]), 32'(e.st));
        check_eq("ctrl", 32'(ctl_a[k]), 32'(e.ctl));
        check_eq("retired", ret_a[k], e.ret);
        check_eq("illegal", 32'(ill_a[k]), 32'(e.ill));
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n && q.size() > 0; i++) step(q.pop_front());
    endtask

    task automatic do_instr(input logic [6:0] op, input int wf, input int wm,
                            input logic z, input int trap_cycles);
        int n;
        gen_instr(op, wf, wm, z, trap_cycles);
        n = q.size();
        run_n(n);
        $display("txn dut%0d op=%b wf=%0d wm=%0d z=%0d cycles=%0d retired_model=%0d",
                 k, op, wf, wm, z, n, ret_m);
    endtask

    task automatic do_reset(input int kk);
        k     = kk;
        rst_v = 3'b111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            op_code   = 7'($urandom);
            mem_ready = 1'b1;
            zero      = rb();
            #1;
            check_eq("rst_ctrl", 32'(ctl_a[k]), 32'h0);
            if (c == 1) begin
                check_eq("rst_state", 32'(st_a[k]), 32'(ST_FETCH));
                check_eq("rst_retired", ret_a[k], 32'h0);
                check_eq("rst_illegal", 32'(ill_a[k]), 32'h0);
            end
        end
        ret_m = 0;
        ill_m = 1'b0;
        q.delete();
        $display("txn dut%0d reset", k);
    endtask

    task automatic rand_instr(input int pool);
        logic [6:0] tbl [7];
        tbl = '{LW, SW, RT, IT, BR, JL, BAD};
        do_instr(tbl[$urandom_range(0, pool - 1)], $urandom_range(0, 3),
                 $urandom_range(0, 3), rb(), 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v = 3'b111; op_code = '0; zero = 1'b0; mem_ready = 1'b0;

        do_reset(0);
        do_instr(RT, 0, 0, 1'b0, 0);
        do_instr(LW, 2, 3, 1'b0, 0);
        do_instr(BR, 0, 0, 1'b1, 0);
        do_instr(BR, 0, 0, 1'b0, 0);
        do_instr(JL, 0, 0, 1'b0, 0);
        do_instr(IT, 1, 0, 1'b0, 0);
        do_instr(SW, 0, 2, 1'b0, 0);
        for (int i = 0; i < 30; i++) rand_instr(5);
        do_instr(BAD, 0, 0, 1'b0, 5);
        do_reset(0);

        // Reset landing in MEMWRITE while memory is ready must suppress MemWrite.
        gen_instr(SW, 0, 0, 1'b0, 0);
        run_n(3);
        @(negedge clk);
        rst_v[k] = 1'b1; op_code = SW; mem_ready = 1'b1;
        #1;
        check_eq("rst_mw_state", 32'(st_a[k]), 32'(ST_MEMWRITE));
        check_eq("rst_mw_ctrl", 32'(ctl_a[k]), 32'h0);
        q.delete(); ret_m = 0; ill_m = 1'b0;
        do_instr(RT, 0, 0, 1'b0, 0);

        do_reset(1);
        for (int i = 0; i < 8; i++) rand_instr(5);
        do_instr(JL, 0, 0, 1'b0, 20);
        do_reset(1);

        do_reset(2);
        do_instr(BAD, 0, 0, 1'b0, 0);
        for (int i = 0; i < 20; i++) rand_instr(7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
